mod_n_counter: RTL and testbench

- Modulo-N up/down counter that drives the 4-bit digit input of the 7-segment hex decoder, one value per display tick.
- Contains a prescaler that turns the board clock (50 MHz on DE10) into a count tick.
- Synchronises two active-low push-buttons: run/pause and single-step.
- Produces a carry/borrow pulse so that counters can be cascaded for multi-digit displays.

---
 rtl/mod_counter_pkg.sv | 16 +
 rtl/mod_n_counter_key_sync.sv | 39 +++
 rtl/mod_n_counter.sv | 117 +++++++++++
 tb/tb_mod_n_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
// Shared definitions for the modulo-N display counter and its helpers.
//   CNT_W            - digit width shared with the 7-segment hex decoder
//   DEFAULT_PRESCALE - board clock cycles per count tick (50 MHz -> 1 Hz)
//   state_t          - run/pause state of the counter
package mod_counter_pkg;

    localparam int CNT_W            = 4;
    localparam int DEFAULT_PRESCALE = 50_000_000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

endpackage

// File: rtl/mod_n_counter_key_sync.sv
// key_sync
// Brings an asynchronous, externally debounced active-low push-button into
// the clk domain and turns each press into a single-cycle pulse.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   key_n   in   raw active-low button level
//   press   out  registered one-cycle pulse on each press (falling edge)
module key_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Reset fills the chain with 1 (button released) so that leaving reset
    // never looks like a press. The pulse is registered, so a key first
    // sampled low at edge k takes effect at edge k+SYNC_STAGES+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
            prev_q <= synced;
            press  <= prev_q & ~synced;
        end
    end

endmodule

// File: rtl/mod_n_counter.sv
// mod_n_counter
// Modulo-N up/down counter with prescaler, run/pause control and
// single-step, driving one digit of a 7-segment display.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_run_n   in   active-low run/pause button (asynchronous)
//   key_step_n  in   active-low single-step button (asynchronous)
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous load strobe (highest priority)
//   load_value  in   value to load, clamped to N-1
//   count       out  current digit value
//   carry       out  one-cycle pulse after a wrap, for cascading digits
//   running     out  1 while in RUN, 0 while in PAUSE
module mod_n_counter
    import mod_counter_pkg::*;
#(
    parameter int N           = 10,
    parameter int PRESCALE    = DEFAULT_PRESCALE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_run_n,
    input  logic             key_step_n,
    input  logic             up_down,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             carry,
    output logic             running
);

    localparam int               PW            = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(N - 1);

    logic             run_press;
    logic             step_press;
    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    presc_q;
    logic             tick;
    logic             advance;
    logic             wrap;
    logic [CNT_W-1:0] next_count;
    logic [CNT_W-1:0] load_clamped;

    key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_step_n),
        .press (step_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Each run press flips between RUN and PAUSE.
    always_comb begin
        state_d = state_q;
        if (run_press) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    assign running = (state_q == ST_RUN);
    assign tick    = running && (presc_q == PRESCALE_LAST);

    // A step that coincides with a run press is swallowed by the toggle.
    assign advance = running ? tick : (step_press && !run_press);

    assign wrap         = up_down ? (count == CNT_MAX) : (count == '0);
    assign next_count   = up_down ? (wrap ? '0 : count + CNT_W'(1))
                                  : (wrap ? CNT_MAX : count - CNT_W'(1));
    assign load_clamped = ({1'b0, load_value} < (CNT_W + 1)'(N)) ? load_value : CNT_MAX;

    // Held at zero while paused or on load, so the first tick afterwards
    // lands a full PRESCALE cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (load || !running || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            carry <= 1'b0;
        end else if (advance) begin
            count <= next_count;
            carry <= wrap;
        end else begin
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter
// Bench for mod_n_counter: a decimal digit (N=10) and a hex digit (N=16)
// share all inputs; a spec-level model predicts both every cycle, and
// directed steps pin the model with hand-computed literals.
module tb_mod_n_counter;

    localparam int PRESCALE = 4;

    logic       clk;
    logic       rst_n;
    logic       key_run_n;
    logic       key_step_n;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count10;
    logic [3:0] count16;
    logic       carry10;
    logic       carry16;
    logic       running10;
    logic       running16;

    int checks = 0;
    int errors = 0;

    mod_n_counter #(.N(10), .PRESCALE(PRESCALE), .SYNC_STAGES(2)) u_dec (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (count10),
        .carry      (carry10),
        .running    (running10)
    );

    mod_n_counter #(.N(16), .PRESCALE(PRESCALE), .SYNC_STAGES(2)) u_hex (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (count16),
        .carry      (carry16),
        .running    (running16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: key samples are kept as a history so that a press
    // (high then low) seen at edge k acts at edge k+3; the prescaler is a
    // phase counted modulo PRESCALE while running.
    int       m_count [2];
    int       m_carry [2];
    int       m_mod   [2] = '{10, 16};
    int       m_running;
    int       m_phase;
    bit [3:0] run_hist;
    bit [3:0] step_hist;
    bit       m_run_press;
    bit       m_step_press;
    bit       m_advance;

    assign m_run_press  = !run_hist[2] && run_hist[3];
    assign m_step_press = !step_hist[2] && step_hist[3];
    assign m_advance    = !load && ((m_running != 0) ? (m_phase == PRESCALE - 1)
                                                     : (m_step_press && !m_run_press));

    function automatic int modelNext(int c, int n, bit ld, int lv, bit adv, bit up);
        if (ld) return (lv < n) ? lv : n - 1;
        if (!adv) return c;
        if (up) return (c + 1) % n;
        return (c + n - 1) % n;
    endfunction

    function automatic int modelCarry(int c, int n, bit ld, bit adv, bit up);
        if (ld || !adv) return 0;
        if (up) return (c == n - 1) ? 1 : 0;
        return (c == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count   <= '{0, 0};
            m_carry   <= '{0, 0};
            m_running <= 1;
            m_phase   <= 0;
            run_hist  <= 4'b1111;
            step_hist <= 4'b1111;
        end else begin
            m_running <= m_running ^ int'(m_run_press);
            m_phase   <= (load || m_running == 0) ? 0 : (m_phase + 1) % PRESCALE;
            run_hist  <= {run_hist[2:0], key_run_n};
            step_hist <= {step_hist[2:0], key_step_n};
            for (int i = 0; i < 2; i++) begin
                m_count[i] <= modelNext(m_count[i], m_mod[i], load, int'(load_value),
                                        m_advance, up_down);
                m_carry[i] <= modelCarry(m_count[i], m_mod[i], load, m_advance, up_down);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput("cmp_count_n10",   int'(count10),   m_count[0]);
        checkOutput("cmp_carry_n10",   int'(carry10),   m_carry[0]);
        checkOutput("cmp_running_n10", int'(running10), m_running);
        checkOutput("cmp_count_n16",   int'(count16),   m_count[1]);
        checkOutput("cmp_carry_n16",   int'(carry16),   m_carry[1]);
        checkOutput("cmp_running_n16", int'(running16), m_running);
    end

    // Drive all synchronous inputs at a falling edge, then let the given
    // number of cycles elapse, ending on a falling edge.
    task automatic applyStimulus(input bit run_n, input bit step_n, input bit ud,
                                 input bit ld, input int lv, input int cycles);
        key_run_n  = run_n;
        key_step_n = step_n;
        up_down    = ud;
        load       = ld;
        load_value = 4'(lv);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 4'd0;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset_count_n10",   int'(count10),   0);
        checkOutput("reset_carry_n10",   int'(carry10),   0);
        checkOutput("reset_running_n10", int'(running10), 1);
        checkOutput("reset_count_n16",   int'(count16),   0);

        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 0, 0, 3);
        checkOutput("pre_first_tick_n10", int'(count10), 0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        checkOutput("first_tick_n10", int'(count10), 1);
        checkOutput("model_first_tick", m_count[0], 1);
        applyStimulus(1, 1, 1, 0, 0, 36);
        checkOutput("wrap_up_count_n10", int'(count10), 0);
        checkOutput("wrap_up_carry_n10", int'(carry10), 1);
        checkOutput("no_wrap_count_n16", int'(count16), 10);
        checkOutput("no_wrap_carry_n16", int'(carry16), 0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        checkOutput("carry_one_cycle_n10", int'(carry10), 0);

        $display("[TB] down count through zero");
        applyStimulus(1, 1, 0, 0, 0, 3);
        checkOutput("wrap_down_count_n10", int'(count10), 9);
        checkOutput("wrap_down_carry_n10", int'(carry10), 1);
        checkOutput("down_count_n16",      int'(count16), 9);

        $display("[TB] pause and single step");
        applyStimulus(0, 1, 0, 0, 0, 5);
        applyStimulus(1, 1, 1, 0, 0, 6);
        checkOutput("paused_running",   int'(running10), 0);
        checkOutput("paused_count_n10", int'(count10),   8);
        checkOutput("model_paused",     m_count[1],      8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 2);
            applyStimulus(1, 1, 1, 0, 0, 3);
        end
        applyStimulus(1, 1, 1, 0, 0, 8);
        checkOutput("stepped_count_n10", int'(count10),   1);
        checkOutput("stepped_count_n16", int'(count16),   11);
        checkOutput("stepped_running",   int'(running16), 0);

        $display("[TB] resume and load on a tick");
        applyStimulus(0, 1, 1, 0, 0, 2);
        applyStimulus(1, 1, 1, 0, 0, 5);
        checkOutput("resumed_running",   int'(running10), 1);
        checkOutput("resumed_count_n10", int'(count10),   1);
        applyStimulus(1, 1, 1, 1, 7, 1);
        checkOutput("load7_count_n10", int'(count10), 7);
        checkOutput("load7_carry_n10", int'(carry10), 0);
        checkOutput("load7_count_n16", int'(count16), 7);
        applyStimulus(1, 1, 1, 0, 0, 3);
        checkOutput("after_load_hold_n10", int'(count10), 7);
        applyStimulus(1, 1, 1, 0, 0, 1);
        checkOutput("after_load_tick_n10", int'(count10), 8);
        checkOutput("model_after_load",    m_count[1],    8);

        $display("[TB] load clamp and hex wrap");
        applyStimulus(1, 1, 1, 1, 12, 1);
        checkOutput("clamp12_count_n10", int'(count10), 9);
        checkOutput("load12_count_n16",  int'(count16), 12);
        applyStimulus(1, 1, 1, 1, 15, 1);
        checkOutput("load15_count_n16", int'(count16), 15);
        applyStimulus(1, 1, 1, 0, 0, 4);
        checkOutput("hex_wrap_count_n16", int'(count16), 0);
        checkOutput("hex_wrap_carry_n16", int'(carry16), 1);
        checkOutput("dec_wrap_count_n10", int'(count10), 0);
        checkOutput("dec_wrap_carry_n10", int'(carry10), 1);

        $display("[TB] simultaneous run and step presses");
        applyStimulus(0, 0, 1, 0, 0, 2);
        applyStimulus(1, 1, 1, 0, 0, 6);
        checkOutput("simul_running", int'(running10), 0);
        applyStimulus(1, 1, 1, 1, 5, 1);
        applyStimulus(1, 1, 1, 0, 0, 2);
        checkOutput("paused_load_count_n10", int'(count10), 5);

        $display("[TB] asynchronous reset mid-cycle");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count_n10",   int'(count10),   0);
        checkOutput("async_rst_carry_n10",   int'(carry10),   0);
        checkOutput("async_rst_running_n10", int'(running10), 1);
        checkOutput("async_rst_count_n16",   int'(count16),   0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 0, 0, 8);
        checkOutput("post_rst_count_n10", int'(count10), 2);
        checkOutput("post_rst_count_n16", int'(count16), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
